ddr_wr_arbiter: RTL and testbench

- Shares the single DDR write-master port between NUM_REQ vin buffer controllers (FBC, PMT, laser vin paths).
- Each requester presents its own req/len/addr/data burst interface and sees a private finish/fifo-read handshake.
- The arbiter grants round-robin, one whole burst at a time, and sits between the vin controllers and the DDR write engine in the ddr_clk_i domain.

---
 rtl/ddr_arb_pkg.sv | 25 ++
 rtl/ddr_wr_arbiter_if.sv | 51 +++++
 rtl/rr_arbiter.sv | 37 +++
 rtl/ddr_wr_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ddr_wr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_arb_pkg.sv
// -----------------------------------------------------------------------------
// ddr_arb_pkg
// Shared definitions for the DDR write-port arbiter: FSM state encoding,
// DDR burst-length width, default watchdog limit and a pointer-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int DDR_LEN_WIDTH      = 8;
  // One extra bit so a length of 0 (meaning 256 beats) is representable.
  localparam int BEAT_CNT_WIDTH     = DDR_LEN_WIDTH + 1;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  // Width of an owner index; never below 1 so a vector can always be declared.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// ddr_wr_arbiter_if
// Bundles the requester-side burst interfaces and the DDR write-engine
// handshake seen by ddr_wr_arbiter. Signal suffixes are from the arbiter's
// point of view.
//   slave  modport : the arbiter (consumes req/len/addr/data, pop, finish)
//   master modport : requesters + DDR engine (drive requests, pops, finish)
// Signals:
//   req_wr_ddr_req_i/len_i/addr_i/data_i  per-requester burst request (packed)
//   req_ddr_fifo_rd_req_o                 per-requester data-pop strobe
//   req_wr_ddr_finish_o                   per-requester burst-done pulse
//   wr_ddr_req_o/len_o/addr_o/data_o      towards DDR write engine
//   ddr_fifo_rd_req_i, wr_ddr_finish_i    from DDR write engine
// -----------------------------------------------------------------------------
interface ddr_wr_arbiter_if
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 30,
  parameter int MEM_DATA_BITS = 256
);

  logic [NUM_REQ-1:0]               req_wr_ddr_req_i;
  logic [NUM_REQ*DDR_LEN_WIDTH-1:0] req_wr_ddr_len_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_wr_ddr_addr_i;
  logic [NUM_REQ*MEM_DATA_BITS-1:0] req_wr_ddr_data_i;
  logic [NUM_REQ-1:0]               req_ddr_fifo_rd_req_o;
  logic [NUM_REQ-1:0]               req_wr_ddr_finish_o;

  logic                             wr_ddr_req_o;
  logic [DDR_LEN_WIDTH-1:0]         wr_ddr_len_o;
  logic [ADDR_WIDTH-1:0]            wr_ddr_addr_o;
  logic                             ddr_fifo_rd_req_i;
  logic [MEM_DATA_BITS-1:0]         wr_ddr_data_o;
  logic                             wr_ddr_finish_i;

  modport slave (
    input  req_wr_ddr_req_i, req_wr_ddr_len_i, req_wr_ddr_addr_i, req_wr_ddr_data_i,
    output req_ddr_fifo_rd_req_o, req_wr_ddr_finish_o,
    output wr_ddr_req_o, wr_ddr_len_o, wr_ddr_addr_o, wr_ddr_data_o,
    input  ddr_fifo_rd_req_i, wr_ddr_finish_i
  );

  modport master (
    output req_wr_ddr_req_i, req_wr_ddr_len_i, req_wr_ddr_addr_i, req_wr_ddr_data_i,
    input  req_ddr_fifo_rd_req_o, req_wr_ddr_finish_o,
    input  wr_ddr_req_o, wr_ddr_len_o, wr_ddr_addr_o, wr_ddr_data_o,
    output ddr_fifo_rd_req_i, wr_ddr_finish_i
  );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first set request found when
// searching upward from (i_last_owner + 1) with wrap-around.
// Ports:
//   i_req        request vector
//   i_last_owner index of the previous winner
//   o_grant      one-hot winner, all-zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_last_owner,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_pick;

  // Requests strictly above the last owner win first; if none, wrap to the
  // full vector. Lowest set bit of the chosen vector is the winner.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask
    assign w_mask[g] = (PTR_W'(g) > i_last_owner);
  end

  assign w_masked = i_req & w_mask;
  assign w_pick   = (w_masked != '0) ? w_masked : i_req;
  assign o_grant  = w_pick & (~w_pick + ONE);

endmodule

// File: rtl/ddr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// ddr_wr_arbiter
// Shares the single DDR write-master port among NUM_REQ requesters, granting
// whole bursts in round-robin order. FSM: IDLE -> BURST -> RELEASE -> IDLE.
// Optional build macro DDR_WR_ARB_TIMEOUT_EN adds a burst watchdog
// (TIMEOUT_CYCLES parameter, timeout_err_o port) that forces a release.
// Ports:
//   ddr_clk_i      clock
//   ddr_rst_n_i    asynchronous active-low reset
//   arb_bus        ddr_wr_arbiter_if.slave (requesters + DDR engine)
//   grant_o        one-hot current owner, 0 when idle
//   len_err_o      sticky: more pops than the latched burst length
//   timeout_err_o  sticky: watchdog fired (only with DDR_WR_ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module ddr_wr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_WIDTH    = 30,
  parameter int MEM_DATA_BITS = 256
`ifdef DDR_WR_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic               ddr_clk_i,
  input  logic               ddr_rst_n_i,
  ddr_wr_arbiter_if.slave    arb_bus,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               len_err_o
`ifdef DDR_WR_ARB_TIMEOUT_EN
  , output logic             timeout_err_o
`endif
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  logic [NUM_REQ-1:0]        r_grant;
  logic [NUM_REQ-1:0]        r_finish;
  logic [PTR_W-1:0]          r_last_owner;
  logic [DDR_LEN_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_wr_req;
  logic [BEAT_CNT_WIDTH-1:0] r_beat_cnt;
  logic                      r_len_err;

  logic [NUM_REQ-1:0]        w_grant;
  logic [DDR_LEN_WIDTH-1:0]  w_new_len;
  logic [ADDR_WIDTH-1:0]     w_new_addr;
  logic [MEM_DATA_BITS-1:0]  w_data;
  logic [PTR_W-1:0]          w_owner_idx;
  logic [BEAT_CNT_WIDTH-1:0] w_len_eff;
  logic                      w_grab;
  logic                      w_release;
  logic                      w_pop;
  logic                      w_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req        (arb_bus.req_wr_ddr_req_i),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant)
  );

  // Slice selection: new winner's len/addr for latching, current owner's data
  // and index for the burst itself.
  always_comb begin
    w_new_len   = '0;
    w_new_addr  = '0;
    w_data      = '0;
    w_owner_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_new_len  = arb_bus.req_wr_ddr_len_i[k*DDR_LEN_WIDTH +: DDR_LEN_WIDTH];
        w_new_addr = arb_bus.req_wr_ddr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (r_grant[k]) begin
        w_data      = arb_bus.req_wr_ddr_data_i[k*MEM_DATA_BITS +: MEM_DATA_BITS];
        w_owner_idx = PTR_W'(k);
      end
    end
  end

  // A latched length of 0 means a full 256-beat burst.
  assign w_len_eff = {(r_len == '0), r_len};
  assign w_pop     = (r_state == ST_BURST) && arb_bus.ddr_fifo_rd_req_i;

  // NOTE: every variable gets a default before the case, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grab      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|arb_bus.req_wr_ddr_req_i) begin
          w_grab      = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (arb_bus.wr_ddr_finish_i || w_timeout) begin
          w_release   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      // One dead cycle lets the finished owner drop its request before the
      // next arbitration.
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      r_grant      <= '0;
      r_finish     <= '0;
      r_last_owner <= '0;
      r_len        <= '0;
      r_addr       <= '0;
      r_wr_req     <= 1'b0;
      r_beat_cnt   <= '0;
      r_len_err    <= 1'b0;
    end else begin
      r_finish <= '0;
      if (w_grab) begin
        r_grant    <= w_grant;
        r_len      <= w_new_len;
        r_addr     <= w_new_addr;
        r_wr_req   <= 1'b1;
        r_beat_cnt <= '0;
      end
      if (w_release) begin
        r_wr_req     <= 1'b0;
        r_finish     <= r_grant;
        r_grant      <= '0;
        r_last_owner <= w_owner_idx;
      end
      if (w_pop) begin
        if (r_beat_cnt == w_len_eff) begin
          r_len_err <= 1'b1;
        end
        // Saturate so a runaway engine cannot wrap back into range.
        if (r_beat_cnt != '1) begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

`ifdef DDR_WR_ARB_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_to_err;

  // Counter value is (BURST cycle - 1); the watchdog fires on the
  // TIMEOUT_CYCLES-th cycle of the burst, exactly like a finish there.
  assign w_timeout = (r_state == ST_BURST) && (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (w_grab) begin
        r_to_cnt <= '0;
      end else if (r_state == ST_BURST) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_to_err <= 1'b1;
      end
    end
  end

  assign timeout_err_o = r_to_err;
`else
  assign w_timeout = 1'b0;
`endif

  assign arb_bus.wr_ddr_req_o          = r_wr_req;
  assign arb_bus.wr_ddr_len_o          = r_len;
  assign arb_bus.wr_ddr_addr_o         = r_addr;
  assign arb_bus.wr_ddr_data_o         = w_data;
  assign arb_bus.req_wr_ddr_finish_o   = r_finish;
  assign arb_bus.req_ddr_fifo_rd_req_o = w_pop ? r_grant : '0;
  assign grant_o                       = r_grant;
  assign len_err_o                     = r_len_err;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr_wr_arbiter
// Self-checking bench for ddr_wr_arbiter (NUM_REQ=2). A table of bursts is
// applied in a loop; pops and finish pulses are checked by a scoreboard fed at
// drive time and drained by a negedge monitor. Hand-written sequences cover
// regrant spacing, length overrun, mid-burst reset and (with
// DDR_WR_ARB_TIMEOUT_EN) the watchdog.
// -----------------------------------------------------------------------------
module tb_ddr_wr_arbiter;

  localparam int NR = 2;
  localparam int AW = 30;
  localparam int DW = 256;

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  len0;
    logic [29:0] addr0;
    logic [7:0]  len1;
    logic [29:0] addr1;
    int          pops;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_len;
    logic [29:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [1:0]    rd;
    logic [DW-1:0] data;
  } pop_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NR-1:0] grant;
  logic len_err;
`ifdef DDR_WR_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic exp_len_err = 1'b0;

  pop_exp_t   pop_q[$];
  logic [1:0] fin_q[$];
  vec_t       vecs[8];

  ddr_wr_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .MEM_DATA_BITS(DW)) bus ();

  ddr_wr_arbiter #(
    .NUM_REQ       (NR),
    .ADDR_WIDTH    (AW),
    .MEM_DATA_BITS (DW)
`ifdef DDR_WR_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) u_dut (
    .ddr_clk_i   (clk),
    .ddr_rst_n_i (rst_n),
    .arb_bus     (bus),
    .grant_o     (grant),
    .len_err_o   (len_err)
`ifdef DDR_WR_ARB_TIMEOUT_EN
    , .timeout_err_o (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] d;
    for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  // Scoreboard drain: forwarded pops and finish pulses must match, in order,
  // what the bench pushed when it drove the engine.
  always @(negedge clk) begin
    if (bus.req_ddr_fifo_rd_req_o != '0) begin
      if (pop_q.size() == 0) begin
        check("unexpected pop fwd", DW'(bus.req_ddr_fifo_rd_req_o), '0);
      end else begin
        pop_exp_t e;
        e = pop_q.pop_front();
        check("pop owner", DW'(bus.req_ddr_fifo_rd_req_o), DW'(e.rd));
        check("pop data", bus.wr_ddr_data_o, e.data);
      end
    end
    if (bus.req_wr_ddr_finish_o != '0) begin
      if (fin_q.size() == 0) begin
        check("unexpected finish", DW'(bus.req_wr_ddr_finish_o), '0);
      end else begin
        logic [1:0] f;
        f = fin_q.pop_front();
        check("finish owner", DW'(bus.req_wr_ddr_finish_o), DW'(f));
      end
    end
  end

  task automatic drive_pop(input logic [1:0] owner);
    logic [DW-1:0] d0, d1;
    pop_exp_t e;
    d0 = rand256();
    d1 = rand256();
    bus.req_wr_ddr_data_i = {d1, d0};
    bus.ddr_fifo_rd_req_i = 1'b1;
    e.rd   = owner;
    e.data = owner[1] ? d1 : d0;
    pop_q.push_back(e);
    tick();
    bus.ddr_fifo_rd_req_i = 1'b0;
  endtask

  task automatic drive_finish(input logic [1:0] owner);
    bus.wr_ddr_finish_i = 1'b1;
    fin_q.push_back(owner);
    tick();
    bus.wr_ddr_finish_i = 1'b0;
  endtask

  task automatic run_burst(input vec_t v, input int r);
    bus.req_wr_ddr_req_i  = v.req;
    bus.req_wr_ddr_len_i  = {v.len1, v.len0};
    bus.req_wr_ddr_addr_i = {v.addr1, v.addr0};
    tick();
    check($sformatf("r%0d wr_req up", r), DW'(bus.wr_ddr_req_o), DW'(1'b1));
    check($sformatf("r%0d grant", r), DW'(grant), DW'(v.exp_grant));
    check($sformatf("r%0d len", r), DW'(bus.wr_ddr_len_o), DW'(v.exp_len));
    check($sformatf("r%0d addr", r), DW'(bus.wr_ddr_addr_o), DW'(v.exp_addr));
    for (int i = 0; i < v.pops; i++) begin
      // Requesters scribble over len/addr mid-burst; outputs must not move.
      bus.req_wr_ddr_len_i  = 16'($urandom);
      bus.req_wr_ddr_addr_i = {30'($urandom), 30'($urandom)};
      drive_pop(v.exp_grant);
    end
    check($sformatf("r%0d len held", r), DW'(bus.wr_ddr_len_o), DW'(v.exp_len));
    check($sformatf("r%0d addr held", r), DW'(bus.wr_ddr_addr_o), DW'(v.exp_addr));
    drive_finish(v.exp_grant);
    bus.req_wr_ddr_req_i = '0;
    check($sformatf("r%0d wr_req down", r), DW'(bus.wr_ddr_req_o), DW'(1'b0));
    check($sformatf("r%0d grant clr", r), DW'(grant), '0);
    check($sformatf("r%0d len_err", r), DW'(len_err), DW'(exp_len_err));
    tick();
    check($sformatf("r%0d idle no req", r), DW'(bus.wr_ddr_req_o), DW'(1'b0));
  endtask

  initial begin
    //          req    len0   addr0            len1   addr1             pops grant  len    addr
    vecs[0] = '{2'b01, 8'd8, 30'h100,         8'd0, 30'h0,           8,  2'b01, 8'd8, 30'h100};
    vecs[1] = '{2'b11, 8'd3, 30'h200,         8'd6, 30'h300,         6,  2'b10, 8'd6, 30'h300};
    vecs[2] = '{2'b11, 8'd5, 30'h400,         8'd2, 30'h500,         5,  2'b01, 8'd5, 30'h400};
    vecs[3] = '{2'b11, 8'd7, 30'h600,         8'd7, 30'h3FFF_FFC0,   7,  2'b10, 8'd7, 30'h3FFF_FFC0};
    vecs[4] = '{2'b11, 8'd1, 30'h0,           8'd9, 30'h800,         1,  2'b01, 8'd1, 30'h0};
    vecs[5] = '{2'b10, 8'd0, 30'h0,           8'd0, 30'h1000,        10, 2'b10, 8'd0, 30'h1000};
    vecs[6] = '{2'b01, 8'd1, 30'h1_2345,      8'd0, 30'h0,           1,  2'b01, 8'd1, 30'h1_2345};
    vecs[7] = '{2'b11, 8'd2, 30'h77,          8'd2, 30'h88,          0,  2'b10, 8'd2, 30'h88};

    bus.req_wr_ddr_req_i  = '0;
    bus.req_wr_ddr_len_i  = '0;
    bus.req_wr_ddr_addr_i = '0;
    bus.req_wr_ddr_data_i = '0;
    bus.ddr_fifo_rd_req_i = 1'b0;
    bus.wr_ddr_finish_i   = 1'b0;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst wr_req", DW'(bus.wr_ddr_req_o), '0);
    check("rst grant", DW'(grant), '0);
    check("rst len", DW'(bus.wr_ddr_len_o), '0);
    check("rst addr", DW'(bus.wr_ddr_addr_o), '0);
    check("rst finish", DW'(bus.req_wr_ddr_finish_o), '0);
    check("rst len_err", DW'(len_err), '0);
    repeat (2) tick();
    #3 rst_n = 1'b1;
    tick();

    // Pop and finish while IDLE are ignored.
    bus.ddr_fifo_rd_req_i = 1'b1;
    bus.wr_ddr_finish_i   = 1'b1;
    tick();
    bus.ddr_fifo_rd_req_i = 1'b0;
    bus.wr_ddr_finish_i   = 1'b0;
    check("idle ignore grant", DW'(grant), '0);
    check("idle ignore wr_req", DW'(bus.wr_ddr_req_o), '0);
    tick();

    // Table-driven bursts: single owner, alternating 1,0,1,0, len 0 = 256.
    for (int r = 0; r < 8; r++) run_burst(vecs[r], r);

    // Single requester holding req: no regrant until two cycles after finish.
    bus.req_wr_ddr_req_i  = 2'b01;
    bus.req_wr_ddr_len_i  = {8'd0, 8'd2};
    bus.req_wr_ddr_addr_i = {30'h0, 30'h40};
    tick();
    check("hold grant1", DW'(grant), DW'(2'b01));
    drive_pop(2'b01);
    drive_pop(2'b01);
    drive_finish(2'b01);
    check("hold f+1 wr_req", DW'(bus.wr_ddr_req_o), '0);
    check("hold f+1 grant", DW'(grant), '0);
    tick();
    check("hold f+2 grant", DW'(grant), '0);
    tick();
    check("hold f+3 grant", DW'(grant), DW'(2'b01));
    check("hold f+3 wr_req", DW'(bus.wr_ddr_req_o), DW'(1'b1));
    drive_finish(2'b01);
    bus.req_wr_ddr_req_i = '0;
    tick();

    // Length overrun: len 4, five pops.
    bus.req_wr_ddr_req_i = 2'b01;
    bus.req_wr_ddr_len_i = {8'd0, 8'd4};
    tick();
    for (int i = 0; i < 4; i++) drive_pop(2'b01);
    check("ovr after 4", DW'(len_err), '0);
    drive_pop(2'b01);
    check("ovr after 5", DW'(len_err), DW'(1'b1));
    drive_finish(2'b01);
    bus.req_wr_ddr_req_i = '0;
    tick();
    tick();
    check("ovr sticky", DW'(len_err), DW'(1'b1));

    // Reset in the middle of a burst, then normal regrant.
    bus.req_wr_ddr_req_i  = 2'b01;
    bus.req_wr_ddr_len_i  = {8'd0, 8'd8};
    bus.req_wr_ddr_addr_i = {30'h0, 30'h200};
    tick();
    check("mid grant", DW'(grant), DW'(2'b01));
    for (int i = 0; i < 3; i++) drive_pop(2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst wr_req", DW'(bus.wr_ddr_req_o), '0);
    check("mid rst grant", DW'(grant), '0);
    check("mid rst addr", DW'(bus.wr_ddr_addr_o), '0);
    check("mid rst len_err", DW'(len_err), '0);
    exp_len_err = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    run_burst('{2'b11, 8'd4, 30'h10, 8'd1, 30'h2000_0000, 1, 2'b10, 8'd1, 30'h2000_0000}, 8);

`ifdef DDR_WR_ARB_TIMEOUT_EN
    // Watchdog: no engine finish, release on the 16th burst cycle.
    bus.req_wr_ddr_req_i = 2'b01;
    bus.req_wr_ddr_len_i = {8'd0, 8'd8};
    tick();
    check("to grant", DW'(grant), DW'(2'b01));
    repeat (15) tick();
    check("to cyc15 wr_req", DW'(bus.wr_ddr_req_o), DW'(1'b1));
    check("to cyc15 err", DW'(timeout_err), '0);
    fin_q.push_back(2'b01);
    tick();
    check("to wr_req drop", DW'(bus.wr_ddr_req_o), '0);
    check("to err", DW'(timeout_err), DW'(1'b1));
    bus.req_wr_ddr_req_i = '0;
    tick();
`endif

    repeat (3) tick();
    check("pops drained", DW'(pop_q.size()), '0);
    check("finishes drained", DW'(fin_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
